// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the unified instruction/data memory.
// Each transaction goes IDLE -> ACCESS (WAIT_CYCLES cycles) -> RESP, which carries the ack.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_wd,
    output logic [DATA_W-1:0] m0_rd,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_wd,
    output logic [DATA_W-1:0] m1_rd,
    output logic              m1_ack,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic              lat_we;
    logic [DATA_W-1:0] lat_adr;
    logic [DATA_W-1:0] lat_wd;
    logic              owner;
    logic              last;
    logic              winner;
    logic              any_req;
    logic              final_access;

    // On contention the requester not served last wins; last resets to 1 so m0 wins first.
    always_comb begin
        any_req = m0_req | m1_req;
        winner  = 1'b0;
        if (m0_req && m1_req) begin
            winner = ~last;
        end else begin
            winner = m1_req;
        end
    end

    assign final_access = (state == ACCESS) && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The latched transaction is immune to requester changes once granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            lat_we  <= 1'b0;
            lat_adr <= '0;
            lat_wd  <= '0;
            owner   <= 1'b0;
            last    <= 1'b1;
            m0_rd   <= '0;
            m1_rd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= winner;
                        lat_we  <= winner ? m1_we  : m0_we;
                        lat_adr <= winner ? m1_adr : m0_adr;
                        lat_wd  <= winner ? m1_wd  : m0_wd;
                        cnt     <= CW'(WAIT_CYCLES - 1);
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!lat_we) begin
                        if (owner) begin
                            m1_rd <= mem_rd;
                        end else begin
                            m0_rd <= mem_rd;
                        end
                    end
                end
                RESP: begin
                    last <= owner;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Address/data come straight from the latches, which only change on a grant.
    assign mem_adr = lat_adr;
    assign mem_wd  = lat_wd;
    assign mem_we  = final_access && lat_we;
    assign busy    = (state != IDLE);
    assign grant   = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    assign m0_ack  = (state == RESP) && !owner;
    assign m1_ack  = (state == RESP) && owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses WAIT_CYCLES=1, instance b uses WAIT_CYCLES=3,
// each with its own word-addressed memory model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;

    logic        a_m0_req, a_m0_we, a_m0_ack, a_m1_req, a_m1_we, a_m1_ack, a_mem_we, a_busy;
    logic [31:0] a_m0_adr, a_m0_wd, a_m0_rd, a_m1_adr, a_m1_wd, a_m1_rd;
    logic [31:0] a_mem_adr, a_mem_wd, a_mem_rd;
    logic [1:0]  a_grant;

    logic        b_m0_req, b_m0_we, b_m0_ack, b_m1_req, b_m1_we, b_m1_ack, b_mem_we, b_busy;
    logic [31:0] b_m0_adr, b_m0_wd, b_m0_rd, b_m1_adr, b_m1_wd, b_m1_rd;
    logic [31:0] b_mem_adr, b_mem_wd, b_mem_rd;
    logic [1:0]  b_grant;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];

    int n_cmp = 0;
    int n_bad = 0;
    int b_we_events = 0;
    int b_ack_events = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(1), .DATA_W(32)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_adr(a_m0_adr), .m0_wd(a_m0_wd),
        .m0_rd(a_m0_rd), .m0_ack(a_m0_ack),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_adr(a_m1_adr), .m1_wd(a_m1_wd),
        .m1_rd(a_m1_rd), .m1_ack(a_m1_ack),
        .mem_we(a_mem_we), .mem_adr(a_mem_adr), .mem_wd(a_mem_wd), .mem_rd(a_mem_rd),
        .grant(a_grant), .busy(a_busy)
    );

    mem_arbiter #(.WAIT_CYCLES(3), .DATA_W(32)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_adr(b_m0_adr), .m0_wd(b_m0_wd),
        .m0_rd(b_m0_rd), .m0_ack(b_m0_ack),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_adr(b_m1_adr), .m1_wd(b_m1_wd),
        .m1_rd(b_m1_rd), .m1_ack(b_m1_ack),
        .mem_we(b_mem_we), .mem_adr(b_mem_adr), .mem_wd(b_mem_wd), .mem_rd(b_mem_rd),
        .grant(b_grant), .busy(b_busy)
    );

    function automatic logic [31:0] preload(int idx);
        case (idx)
            4:       return 32'hDEADBEEF;
            5:       return 32'hCAFEF00D;
            default: return 32'h0;
        endcase
    endfunction

    // Memory models: combinational read, write on the clock edge while mem_we is high.
    assign a_mem_rd = mem_a[6'(a_mem_adr >> 2)];
    assign b_mem_rd = mem_b[6'(b_mem_adr >> 2)];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= preload(i);
        end else if (a_mem_we) begin
            mem_a[6'(a_mem_adr >> 2)] <= a_mem_wd;
        end
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= preload(i);
        end else if (b_mem_we) begin
            mem_b[6'(b_mem_adr >> 2)] <= b_mem_wd;
        end
    end

    always @(posedge clk) begin
        if (b_mem_we) b_we_events <= b_we_events + 1;
        if (b_m0_ack || b_m1_ack) b_ack_events <= b_ack_events + 1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_clear = 1'b1;
        a_m0_req = 0; a_m0_we = 0; a_m0_adr = 0; a_m0_wd = 0;
        a_m1_req = 0; a_m1_we = 0; a_m1_adr = 0; a_m1_wd = 0;
        b_m0_req = 0; b_m0_we = 0; b_m0_adr = 0; b_m0_wd = 0;
        b_m1_req = 0; b_m1_we = 0; b_m1_adr = 0; b_m1_wd = 0;
        next_cycle();
        next_cycle();
        sample();
        n_cmp++; if (a_grant !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_a_grant: got %b want 00", a_grant); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_a_busy: got %b want 0", a_busy); end
        n_cmp++; if ({a_m0_ack, a_m1_ack, a_mem_we} !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_a_strobes: got %b want 000", {a_m0_ack, a_m1_ack, a_mem_we}); end
        n_cmp++; if ({a_m0_rd, a_m1_rd, a_mem_adr, a_mem_wd} !== 128'h0) begin n_bad++; $display("[TB] FAIL reset_a_data: got %h want 0", {a_m0_rd, a_m1_rd, a_mem_adr, a_mem_wd}); end
        n_cmp++; if ({b_grant, b_busy, b_m0_ack, b_m1_ack, b_mem_we} !== 6'b0) begin n_bad++; $display("[TB] FAIL reset_b_ctrl: got %b want 000000", {b_grant, b_busy, b_m0_ack, b_m1_ack, b_mem_we}); end
        next_cycle();
        reset = 1'b0; mem_clear = 1'b0;
        next_cycle();
    endtask

    task automatic test_read();
        a_m0_req = 1; a_m0_we = 0; a_m0_adr = 32'h10;
        sample();
        n_cmp++; if (a_grant !== 2'b00 || a_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL read_c0_idle: got grant=%b busy=%b want 00/0", a_grant, a_busy); end
        next_cycle();
        sample();
        n_cmp++; if (a_grant !== 2'b01) begin n_bad++; $display("[TB] FAIL read_c1_grant: got %b want 01", a_grant); end
        n_cmp++; if (a_mem_adr !== 32'h10 || a_mem_we !== 1'b0 || a_busy !== 1'b1) begin n_bad++; $display("[TB] FAIL read_c1_mem: got adr=%h we=%b busy=%b want 10/0/1", a_mem_adr, a_mem_we, a_busy); end
        next_cycle();
        sample();
        n_cmp++; if (a_m0_ack !== 1'b1 || a_m1_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL read_c2_ack: got m0=%b m1=%b want 1/0", a_m0_ack, a_m1_ack); end
        n_cmp++; if (a_m0_rd !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL read_c2_rd: got %h want deadbeef", a_m0_rd); end
        next_cycle();
        a_m0_req = 0;
        sample();
        n_cmp++; if (a_busy !== 1'b0 || a_m0_ack !== 1'b0 || a_grant !== 2'b00) begin n_bad++; $display("[TB] FAIL read_c3_idle: got busy=%b ack=%b grant=%b want 0/0/00", a_busy, a_m0_ack, a_grant); end
        next_cycle();
    endtask

    task automatic test_write();
        int we_cnt;
        we_cnt = 0;
        a_m1_req = 1; a_m1_we = 1; a_m1_adr = 32'h20; a_m1_wd = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) a_m1_req = 0;
            sample();
            if (a_mem_we === 1'b1) begin
                we_cnt++;
                n_cmp++; if (i != 1 || a_mem_adr !== 32'h20 || a_mem_wd !== 32'h12345678) begin n_bad++; $display("[TB] FAIL write_pulse: cycle %0d adr=%h wd=%h want cycle 1 20/12345678", i, a_mem_adr, a_mem_wd); end
            end
            n_cmp++; if (a_m1_ack !== (i == 2) || a_m0_ack !== 1'b0) begin n_bad++; $display("[TB] FAIL write_ack c%0d: got m1=%b m0=%b want %b/0", i, a_m1_ack, a_m0_ack, (i == 2)); end
            next_cycle();
        end
        n_cmp++; if (we_cnt != 1) begin n_bad++; $display("[TB] FAIL write_we_count: got %0d want 1", we_cnt); end
        n_cmp++; if (a_m1_rd !== 32'h0) begin n_bad++; $display("[TB] FAIL write_rd_unchanged: got %h want 0", a_m1_rd); end
        a_m0_req = 1; a_m0_we = 0; a_m0_adr = 32'h20;
        next_cycle();
        next_cycle();
        sample();
        n_cmp++; if (a_m0_ack !== 1'b1 || a_m0_rd !== 32'h12345678) begin n_bad++; $display("[TB] FAIL write_readback: got ack=%b rd=%h want 1/12345678", a_m0_ack, a_m0_rd); end
        next_cycle();
        a_m0_req = 0;
        next_cycle();
    endtask

    task automatic test_fairness();
        logic       e0, e1;
        logic [1:0] eg;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        a_m0_req = 1; a_m0_we = 0; a_m0_adr = 32'h10;
        a_m1_req = 1; a_m1_we = 0; a_m1_adr = 32'h20;
        for (int i = 0; i < 12; i++) begin
            e0 = (i == 2) || (i == 8);
            e1 = (i == 5) || (i == 11);
            eg = ((i % 3) == 0) ? 2'b00 : ((((i / 3) % 2) == 1) ? 2'b10 : 2'b01);
            sample();
            n_cmp++; if (a_grant !== eg) begin n_bad++; $display("[TB] FAIL fair_grant c%0d: got %b want %b", i, a_grant, eg); end
            n_cmp++; if (a_m0_ack !== e0 || a_m1_ack !== e1) begin n_bad++; $display("[TB] FAIL fair_ack c%0d: got %b%b want %b%b", i, a_m0_ack, a_m1_ack, e0, e1); end
            next_cycle();
        end
        a_m0_req = 0; a_m1_req = 0;
        sample();
        n_cmp++; if (a_m0_rd !== 32'hDEADBEEF || a_m1_rd !== 32'h12345678) begin n_bad++; $display("[TB] FAIL fair_rd: got %h/%h want deadbeef/12345678", a_m0_rd, a_m1_rd); end
        next_cycle();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            sample();
            n_cmp++; if ({a_mem_we, a_grant, a_busy} !== 4'b0000 || a_m1_rd !== 32'h12345678) begin n_bad++; $display("[TB] FAIL idle c%0d: got we/grant/busy=%b rd=%h want 0000/12345678", i, {a_mem_we, a_grant, a_busy}, a_m1_rd); end
            next_cycle();
        end
    endtask

    task automatic test_wait_states();
        b_m0_req = 1; b_m0_we = 0; b_m0_adr = 32'h14;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) b_m0_req = 0;
            sample();
            n_cmp++; if (b_busy !== (i >= 1 && i <= 4) || b_grant !== ((i >= 1 && i <= 4) ? 2'b01 : 2'b00)) begin n_bad++; $display("[TB] FAIL wait_state c%0d: got busy=%b grant=%b", i, b_busy, b_grant); end
            n_cmp++; if (b_m0_ack !== (i == 4) || b_m1_ack !== 1'b0 || b_mem_we !== 1'b0) begin n_bad++; $display("[TB] FAIL wait_ack c%0d: got ack=%b%b we=%b want %b0/0", i, b_m0_ack, b_m1_ack, b_mem_we, (i == 4)); end
            if (i == 4) begin
                n_cmp++; if (b_m0_rd !== 32'hCAFEF00D) begin n_bad++; $display("[TB] FAIL wait_rd: got %h want cafef00d", b_m0_rd); end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        int we0, ack0;
        we0 = b_we_events; ack0 = b_ack_events;
        b_m0_req = 1; b_m0_we = 1; b_m0_adr = 32'h30; b_m0_wd = 32'hAAAA5555;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
        n_cmp++; if ({b_mem_we, b_grant, b_busy, b_m0_ack, b_m1_ack} !== 6'b0) begin n_bad++; $display("[TB] FAIL midreset_ctrl: got %b want 000000", {b_mem_we, b_grant, b_busy, b_m0_ack, b_m1_ack}); end
        n_cmp++; if ({b_mem_adr, b_mem_wd, b_m0_rd} !== 96'h0) begin n_bad++; $display("[TB] FAIL midreset_data: got %h want 0", {b_mem_adr, b_mem_wd, b_m0_rd}); end
        b_m0_req = 0; b_m0_we = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) next_cycle();
        n_cmp++; if (b_we_events != we0 || b_ack_events != ack0) begin n_bad++; $display("[TB] FAIL midreset_no_effect: got we=%0d ack=%0d want %0d/%0d", b_we_events, b_ack_events, we0, ack0); end
        b_m0_req = 1; b_m0_adr = 32'h10;
        b_m1_req = 1; b_m1_we = 0; b_m1_adr = 32'h14;
        next_cycle();
        sample();
        n_cmp++; if (b_grant !== 2'b01) begin n_bad++; $display("[TB] FAIL midreset_contend_grant: got %b want 01", b_grant); end
        next_cycle();
        next_cycle();
        next_cycle();
        sample();
        n_cmp++; if (b_m0_ack !== 1'b1 || b_m1_ack !== 1'b0 || b_m0_rd !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL midreset_contend_ack: got %b%b rd=%h want 10/deadbeef", b_m0_ack, b_m1_ack, b_m0_rd); end
        next_cycle();
        b_m0_req = 0; b_m1_req = 0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_fairness();
        test_idle();
        test_wait_states();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
